// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master slice.
//   FRAME_W         : frame width in bits
//   MODE0..MODE3    : {CPOL, CPHA} encodings
//   spi_mst_state_t : master FSM states
//   IDLE_WORD       : value of an idle line / reset receive word
//   shift_in_top    : right shift with a new bit entering at the MSB
package spi_pkg;

  localparam int FRAME_W = 18;
  localparam int EDGE_W  = 6;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GUARD = 3'd4
  } spi_mst_state_t;

  localparam logic [FRAME_W-1:0] IDLE_WORD = 18'h3FFFF;

  // Both shift registers move LSB-first: the bit at [0] leaves, a new bit
  // enters at the top.
  function automatic logic [FRAME_W-1:0] shift_in_top(input logic b,
                                                      input logic [FRAME_W-1:0] w);
    return {b, w[FRAME_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host and SPI-pin bundle of the SPI master.
//   spi_mode, start, tx_data, abort : host requests
//   busy, rx_data, rx_valid         : host status / result
//   sclk, ss_n, mosi, miso          : SPI pins
// Handshake: start is a request accepted on a clock edge where busy=0
// (busy rises after that edge); there is no ready and requests seen while
// busy=1 are dropped. rx_valid is a one-cycle push strobe with rx_data valid
// in the same cycle; the host cannot stall it.
interface spi_master_if;

  logic [1:0]                  spi_mode;
  logic                        start;
  logic [spi_pkg::FRAME_W-1:0] tx_data;
  logic                        abort;
  logic                        miso;
  logic                        sclk;
  logic                        ss_n;
  logic                        mosi;
  logic                        busy;
  logic [spi_pkg::FRAME_W-1:0] rx_data;
  logic                        rx_valid;

  modport master (
    input  spi_mode, start, tx_data, abort, miso,
    output sclk, ss_n, mosi, busy, rx_data, rx_valid
  );

  modport slave (
    output spi_mode, start, tx_data, abort, miso,
    input  sclk, ss_n, mosi, busy, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial clock divider.
//   sys_clock, reset_n : clock, async active-low reset
//   en                 : run the divider; low holds sclk at cpol
//   cpol               : idle level of sclk
//   sclk               : registered serial clock
//   lead_stb/trail_stb : high in the cycle whose closing edge toggles sclk
//                        away from / back to cpol
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clock,
  input  logic reset_n,
  input  logic en,
  input  logic cpol,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;  // 0: next toggle is a leading edge
  logic          tick;

  assign tick      = en && (cnt == CNT_LAST);
  assign lead_stb  = tick && !phase;
  assign trail_stb = tick && phase;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
      sclk  <= cpol;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
      sclk  <= ~sclk;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-slave SPI master: one FRAME_W-bit LSB-first frame per accepted
// start, any SPI mode, CLK_DIV sys_clock cycles per sclk half-period.
//   sys_clock, reset_n : clock, async active-low reset
//   bus (master)       : host request/result and SPI pins, see spi_master_if
//   state_dbg          : current FSM state
// Build option SPI_MASTER_LOOPBACK_EN: receive path samples the internal
// mosi register instead of miso (bring-up self-test, rx_data == tx_data).
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic            sys_clock,
  input  logic            reset_n,
  spi_master_if.master    bus,
  output spi_mst_state_t  state_dbg
);

  localparam int                TW        = $clog2(CLK_DIV);
  localparam logic [TW-1:0]     TMR_LAST  = TW'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * FRAME_W);

  spi_mst_state_t     state;
  logic               cpol_q, cpha_q;
  logic [FRAME_W-1:0] tx_sh, rx_sh, rx_data_q;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [TW-1:0]      tmr;
  logic               ss_n_q, mosi_q, busy_q, rx_valid_q;

  logic gen_en, gen_cpol, sclk_w, lead_stb, trail_stb;
  logic sample_stb, shift_stb, rx_bit;

  // The divider already runs in SETUP so that its first tick lands exactly
  // CLK_DIV cycles after the accept; it stops after the last edge and at
  // once on abort so sclk returns to CPOL on the abort edge.
  assign gen_en   = !bus.abort &&
                    ((state == SETUP) || ((state == XFER) && (edge_cnt != EDGE_LAST)));
  assign gen_cpol = (state == IDLE) ? bus.spi_mode[1] : cpol_q;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .en        (gen_en),
    .cpol      (gen_cpol),
    .sclk      (sclk_w),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  assign sample_stb = cpha_q ? trail_stb : lead_stb;
  assign shift_stb  = cpha_q ? lead_stb  : trail_stb;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = bus.miso;
`endif

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sh      <= IDLE_WORD;
      rx_sh      <= IDLE_WORD;
      edge_cnt   <= '0;
      tmr        <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b1;
      busy_q     <= 1'b0;
      rx_data_q  <= IDLE_WORD;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cpol_q   <= bus.spi_mode[1];
            cpha_q   <= bus.spi_mode[0];
            edge_cnt <= '0;
            tmr      <= '0;
            rx_sh    <= IDLE_WORD;
            busy_q   <= 1'b1;
            ss_n_q   <= 1'b0;
            state    <= SETUP;
            // CPHA=0 presents bit 0 before the first edge, so it is consumed
            // here and the register holds the bits still to send.
            if (!bus.spi_mode[0]) begin
              mosi_q <= bus.tx_data[0];
              tx_sh  <= shift_in_top(1'b1, bus.tx_data);
            end else begin
              tx_sh  <= bus.tx_data;
            end
          end
        end
        SETUP, XFER: begin
          if (bus.abort) begin
            ss_n_q <= 1'b1;
            mosi_q <= 1'b1;
            tmr    <= '0;
            state  <= GUARD;
          end else begin
            if (lead_stb || trail_stb) edge_cnt <= edge_cnt + 1'b1;
            if (sample_stb) rx_sh <= shift_in_top(rx_bit, rx_sh);
            if (shift_stb) begin
              mosi_q <= tx_sh[0];
              tx_sh  <= shift_in_top(1'b1, tx_sh);
            end
            if ((state == SETUP) && lead_stb) state <= XFER;
            // After edge 36 the last half-period still runs out before HOLD.
            if ((state == XFER) && (edge_cnt == EDGE_LAST)) begin
              if (tmr == TMR_LAST) begin
                tmr    <= '0;
                mosi_q <= 1'b1;
                state  <= HOLD;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (bus.abort) begin
            ss_n_q <= 1'b1;
            mosi_q <= 1'b1;
            tmr    <= '0;
            state  <= GUARD;
          end else if (tmr == TMR_LAST) begin
            tmr        <= '0;
            ss_n_q     <= 1'b1;
            rx_data_q  <= rx_sh;
            rx_valid_q <= 1'b1;
            state      <= GUARD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        GUARD: begin
          if (tmr == TMR_LAST) begin
            tmr    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk     = sclk_w;
  assign bus.ss_n     = ss_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign state_dbg    = state;

endmodule

// File: doc/spi_master.md
# spi_master

Single-slave SPI master that sends and receives one 18-bit frame per request, LSB first, in any of the four SPI modes. It sits between the host or command logic and the off-block SPI slave. It drives `ss_n`, `sclk` and `mosi`, samples `miso`, and returns the received word with a one-cycle valid strobe. Everything runs in `sys_clock`; `sclk` is a registered, divided version of it.

## Interface
- `CLK_DIV`, default 4: `sys_clock` cycles per `sclk` half-period; legal range is ≥2.
- `FRAME_W`, default 18: frame width in bits, taken from the package.
- `sys_clock`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `spi_mode`  in  2  {CPOL, CPHA}; sampled only on an accepted `start`.
- `start`  in  1  frame request; accepted only when `busy`=0.
- `tx_data`  in  18  word to transmit; captured on an accepted `start`.
- `abort`  in  1  terminates the current frame.
- `miso`  in  1  serial data from the slave.
- `sclk`  out  1  serial clock.
- `ss_n`  out  1  slave select, active-low.
- `mosi`  out  1  serial data to the slave.
- `busy`  out  1  high from an accepted `start` until the block returns to IDLE.
- `rx_data`  out  18  last completed received word.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is updated in the same cycle.

## Operation
- States: IDLE → SETUP → XFER → HOLD → GUARD → IDLE.
- IDLE
  - `ss_n`=1, `mosi`=1.
  - `sclk` tracks the live `spi_mode[1]` (registered).
  - On `start`: latch the mode and `tx_data`, clear counters, set `busy`, go to SETUP.
- SETUP
  - `ss_n`=0 for CLK_DIV cycles; `sclk` stays at CPOL.
  - CPHA=0: drive `mosi`=`tx_data[0]` on entry.
- XFER
  - 2×18 `sclk` edges, one every CLK_DIV cycles; the first edge is the leading edge.
  - CPHA=0: sample `miso` on leading edges; shift `mosi` to the next bit on trailing edges, except after the last bit.
  - CPHA=1: shift `mosi` on leading edges (bit 0 on the first leading edge); sample `miso` on trailing edges.
  - Receive shift register: the new bit enters at bit 17 and the register shifts right, so after 18 samples the first bit received sits at bit 0.
  - Transmit shifts in 1s from the top; after the last bit, `mosi`=1.
  - The 6-bit edge counter ends at 36.
- HOLD: CLK_DIV cycles with `sclk` at CPOL and `ss_n`=0.
- GUARD
  - On entry: `ss_n`=1, `rx_data` updated from the shift register, `rx_valid` pulses.
  - Lasts CLK_DIV cycles; `busy` stays high.
  - On exit to IDLE, `busy` drops.
- `abort` in SETUP, XFER or HOLD
  - Next cycle: `ss_n`=1, `sclk`=CPOL, `mosi`=1, go to GUARD.
  - No `rx_valid`; `rx_data` unchanged.
- `abort` in IDLE or GUARD: no effect.
- `start` while `busy`=1 is dropped; it is not queued.
- `start` and `abort` in the same IDLE cycle: the frame starts and `abort` is ignored.
- Changes to `spi_mode` or `tx_data` while `busy`=1 have no effect.

## Timing
- Reset values: `sclk`=0, `ss_n`=1, `mosi`=1, `busy`=0, `rx_valid`=0, `rx_data`=18'h3FFFF, state IDLE.
- Assertion of `reset_n` mid-frame forces these values immediately, with no `rx_valid`.
- All outputs are registered. `start` sampled at edge T0 gives `ss_n`=0 and `busy`=1 after T0.
- First `sclk` edge: T0+CLK_DIV. Edge k (1..36) occurs at T0+k·CLK_DIV.
- `ss_n` rises and `rx_valid` pulses at T0+38·CLK_DIV.
- `busy` falls at T0+39·CLK_DIV; the earliest next accept is at that edge.
- `miso` is sampled on the internal `sys_clock` edge that produces the `sclk` sampling edge, with no synchronizer: the slave is clocked by `sclk`.

## Configuration
- `SPI_MASTER_LOOPBACK_EN`
  - Defined: the receive path samples the internal `mosi` register instead of `miso`; `miso` is ignored. Used for bring-up self-test, where `rx_data` equals `tx_data`.
  - Undefined: `miso` is sampled normally.

## Structure
- Package `spi_pkg`:
  - `FRAME_W`=18.
  - Mode constants `MODE0`..`MODE3` (2'b00..2'b11).
  - State enum `spi_mst_state_t` {IDLE, SETUP, XFER, HOLD, GUARD}.
  - Idle word constant 18'h3FFFF.
- Sub-module `spi_sclk_gen`:
  - Divider that produces one-cycle `lead_stb`/`trail_stb` strobes and a registered `sclk`.
  - Driven by `en`, `cpol` and CLK_DIV.
- The top level holds the FSM, shift registers and counters.

## Test plan
- Mode 0, CLK_DIV=4, `tx_data`=18'h2A5A5, slave model returns 18'h15A5A.
  - Required: `mosi` bit sequence is LSB first; `rx_data`=18'h15A5A.
  - Required: `rx_valid` exactly 152 cycles after the `start` edge; `busy` falls 4 cycles later.
- Modes 1, 2 and 3, each with `tx_data`=18'h00001.
  - Required: `sclk` idles at CPOL.
  - Required: sampling and shift edges match CPHA.
  - Required: 18 `sclk` cycles per frame; round trip against the existing `spi_slave` returns the expected word.
- `start` held high for 200 cycles.
  - Required: exactly one frame per accept.
  - Required: `ss_n` high for ≥4 cycles between frames; no start accepted while `busy`=1.
- `abort` at `sclk` edge 10.
  - Required: next cycle `ss_n`=1 and `sclk`=CPOL; no `rx_valid`; `rx_data` holds its previous value; `busy` falls CLK_DIV cycles later.
- `reset_n` pulsed low mid-XFER.
  - Required: all outputs take their reset values asynchronously; the next `start` runs a clean full frame.
- With `SPI_MASTER_LOOPBACK_EN` defined, `tx_data`=18'h3C3C3 with `miso` tied to 0: required `rx_data`=18'h3C3C3.
